execute: RTL and testbench

//  Execute stage of the MIPS pipeline. Sits directly downstream of decode.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 rtl/execute.sv | 198 +++++++++++++++++++
 tb/tb_execute.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/func field encodings, ALU-op and mult/div enums shared by
// the fetch, decode and execute stages.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_LINK, ALU_HI, ALU_LO
  } alu_op_e;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier and restoring divider with
// the HI/LO registers. One iteration per cycle for MD_CYCLES cycles.
// Divider datapath is present only when EXEC_DIV_EN is defined.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset (aborts any operation)
//   i_start, i_op       launch an operation (only honoured while idle)
//   i_a, i_b            rs / rt operands, latched on the start edge
//   o_busy              operation in flight
//   o_hi, o_lo          HI/LO registers
//
// state   | meaning
// MD_IDLE | waiting for start; HI/LO stable
// MD_BUSY | iterating; HI/LO written on the edge that ends this state
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MD_CYCLES  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  md_op_e                i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  md_state_e               r_state, w_state_nxt;
  logic [CW-1:0]           r_count;
  logic [DATA_WIDTH-1:0]   r_work_hi, r_work_lo, r_opnd, r_hi, r_lo;
  logic                    r_neg_res;
  logic                    w_load, w_done, w_signed, w_a_neg, w_b_neg, w_is_div_op;
  logic [DATA_WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [DATA_WIDTH:0]     w_mul_sum;
  logic [DATA_WIDTH-1:0]   w_mul_hi, w_mul_lo;
  logic [DATA_WIDTH-1:0]   w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;
  logic [2*DATA_WIDTH-1:0] w_prod, w_prod_fix;

  assign w_load   = i_start && (r_state == MD_IDLE);
  assign w_done   = (r_state == MD_BUSY) && (r_count == CW'(1));
  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_a_neg  = w_signed & i_a[DATA_WIDTH-1];
  assign w_b_neg  = w_signed & i_b[DATA_WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  // Multiplier: {work_hi, work_lo} starts as {0, |b|}; add |a| into the upper
  // half when the low bit is set, then shift the whole thing right.
  assign w_mul_sum  = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi   = w_mul_sum[DATA_WIDTH:1];
  assign w_mul_lo   = {w_mul_sum[0], r_work_lo[DATA_WIDTH-1:1]};
  assign w_prod     = {w_mul_hi, w_mul_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

`ifdef EXEC_DIV_EN
  logic                  r_is_div, r_neg_rem, r_dbz;
  logic [DATA_WIDTH-1:0] r_dividend;
  logic [DATA_WIDTH:0]   w_rem_sh;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_sub, w_div_hi, w_div_lo;

  assign w_is_div_op = (i_op == MD_DIV) || (i_op == MD_DIVU);

  // Restoring divider: work_hi is the partial remainder, work_lo shifts the
  // dividend out and the quotient in. The subtraction fits in DATA_WIDTH
  // bits because it is only kept when rem_sh >= divisor.
  assign w_rem_sh  = {r_work_hi, r_work_lo[DATA_WIDTH-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_opnd};
  assign w_rem_sub = w_rem_sh[DATA_WIDTH-1:0] - r_opnd;
  assign w_div_hi  = w_ge ? w_rem_sub : w_rem_sh[DATA_WIDTH-1:0];
  assign w_div_lo  = {r_work_lo[DATA_WIDTH-2:0], w_ge};

  always_comb begin
    w_step_hi = w_mul_hi;
    w_step_lo = w_mul_lo;
    w_fin_hi  = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    w_fin_lo  = w_prod_fix[DATA_WIDTH-1:0];
    if (r_is_div) begin
      w_step_hi = w_div_hi;
      w_step_lo = w_div_lo;
      if (r_dbz) begin
        w_fin_hi = r_dividend;
        w_fin_lo = '1;
      end else begin
        w_fin_hi = r_neg_rem ? -w_div_hi : w_div_hi;
        w_fin_lo = r_neg_res ? -w_div_lo : w_div_lo;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_div   <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dbz      <= 1'b0;
      r_dividend <= '0;
    end else if (w_load) begin
      r_is_div   <= w_is_div_op;
      r_neg_rem  <= w_a_neg;
      r_dbz      <= (i_b == '0);
      r_dividend <= i_a;
    end
  end
`else
  assign w_is_div_op = 1'b0;
  assign w_step_hi   = w_mul_hi;
  assign w_step_lo   = w_mul_lo;
  assign w_fin_hi    = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_fin_lo    = w_prod_fix[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= MD_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_state_nxt = MD_BUSY;
      MD_BUSY: if (w_done)  w_state_nxt = MD_IDLE;
      default:              w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_work_hi <= '0;
      r_work_lo <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (w_load) begin
      r_count   <= CW'(MD_CYCLES);
      r_work_hi <= '0;
      r_work_lo <= w_is_div_op ? w_a_mag : w_b_mag;
      r_opnd    <= w_is_div_op ? w_b_mag : w_a_mag;
      r_neg_res <= w_a_neg ^ w_b_neg;
    end else if (r_state == MD_BUSY) begin
      r_count   <= r_count - CW'(1);
      r_work_hi <= w_step_hi;
      r_work_lo <= w_step_lo;
      if (w_done) begin
        r_hi <= w_fin_hi;
        r_lo <= w_fin_lo;
      end
    end
  end

  assign o_busy = (r_state == MD_BUSY);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/execute.sv
// execute: MIPS execute stage. Registers the ALU result, destination register,
// write enable and branch/jump resolution one cycle after accept, and drives
// stall while the mult/div unit is busy.
// Config macro: EXEC_DIV_EN (DIV/DIVU use the divider; otherwise they are NOPs).
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   enable_execute                 decoded instruction valid (taken when stall=0)
//   pc, opcode, func, rt, rd, sa   decoded fields
//   imm                            [15:0] I-type immediate, [25:0] J-type index
//   rs_data, rt_data               register operands
//   alu_result, dest_reg, reg_write, branch_taken, branch_target, valid_out
//   stall                          mult/div busy; upstream holds its instruction
module execute
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MD_CYCLES  = 32,
  parameter int LINK_REG   = 31
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable_execute,
  input  logic [31:0]           pc,
  input  logic [5:0]            opcode,
  input  logic [5:0]            func,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            sa,
  input  logic [25:0]           imm,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic [4:0]            dest_reg,
  output logic                  reg_write,
  output logic                  branch_taken,
  output logic [31:0]           branch_target,
  output logic                  valid_out,
  output logic                  stall
);

  alu_op_e               w_alu_op;
  md_op_e                w_md_op;
  logic                  w_accept, w_use_imm, w_zext, w_var_shift;
  logic                  w_we, w_taken, w_md_start, w_md_busy, w_lt, w_ltu;
  logic [4:0]            w_dest, w_shamt;
  logic [31:0]           w_pc4, w_pc8, w_br_target, w_j_target, w_target;
  logic [DATA_WIDTH-1:0] w_sext, w_zimm, w_opb, w_result, w_hi, w_lo;

  assign w_accept    = enable_execute & ~w_md_busy;
  assign w_pc4       = pc + 32'd4;
  assign w_pc8       = pc + 32'd8;
  assign w_br_target = w_pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
  assign w_j_target  = {w_pc4[31:28], imm, 2'b00};
  assign w_sext      = {{(DATA_WIDTH-16){imm[15]}}, imm[15:0]};
  assign w_zimm      = {{(DATA_WIDTH-16){1'b0}}, imm[15:0]};
  assign w_opb       = w_use_imm ? (w_zext ? w_zimm : w_sext) : rt_data;
  assign w_shamt     = w_var_shift ? rs_data[4:0] : sa;
  assign w_lt        = $signed(rs_data) < $signed(w_opb);
  assign w_ltu       = rs_data < w_opb;

  always_comb begin
    w_alu_op    = ALU_NONE;
    w_use_imm   = 1'b0;
    w_zext      = 1'b0;
    w_var_shift = 1'b0;
    w_dest      = rt;
    w_we        = 1'b0;
    w_taken     = 1'b0;
    w_target    = w_br_target;
    w_md_start  = 1'b0;
    w_md_op     = MD_MULT;
    case (opcode)
      OP_RTYPE: begin
        w_dest = rd;
        w_we   = 1'b1;
        case (func)
          FN_SLL:  w_alu_op = ALU_SLL;
          FN_SRL:  w_alu_op = ALU_SRL;
          FN_SRA:  w_alu_op = ALU_SRA;
          FN_SLLV: begin w_alu_op = ALU_SLL; w_var_shift = 1'b1; end
          FN_SRLV: begin w_alu_op = ALU_SRL; w_var_shift = 1'b1; end
          FN_SRAV: begin w_alu_op = ALU_SRA; w_var_shift = 1'b1; end
          FN_JR: begin
            w_we     = 1'b0;
            w_taken  = 1'b1;
            w_target = 32'(rs_data);
          end
          FN_MFHI: w_alu_op = ALU_HI;
          FN_MFLO: w_alu_op = ALU_LO;
          FN_MULT:  begin w_we = 1'b0; w_md_start = 1'b1; w_md_op = MD_MULT;  end
          FN_MULTU: begin w_we = 1'b0; w_md_start = 1'b1; w_md_op = MD_MULTU; end
`ifdef EXEC_DIV_EN
          FN_DIV:   begin w_we = 1'b0; w_md_start = 1'b1; w_md_op = MD_DIV;   end
          FN_DIVU:  begin w_we = 1'b0; w_md_start = 1'b1; w_md_op = MD_DIVU;  end
`else
          FN_DIV, FN_DIVU: w_we = 1'b0;
`endif
          FN_ADD, FN_ADDU: w_alu_op = ALU_ADD;
          FN_SUBU: w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_XOR:  w_alu_op = ALU_XOR;
          FN_NOR:  w_alu_op = ALU_NOR;
          FN_SLT:  w_alu_op = ALU_SLT;
          FN_SLTU: w_alu_op = ALU_SLTU;
          default: w_we = 1'b0;
        endcase
      end
      OP_J: begin
        w_taken  = 1'b1;
        w_target = w_j_target;
      end
      OP_JAL: begin
        w_taken  = 1'b1;
        w_target = w_j_target;
        w_we     = 1'b1;
        w_dest   = 5'(LINK_REG);
        w_alu_op = ALU_LINK;
      end
      OP_BEQ:  w_taken = (rs_data == rt_data);
      OP_BNE:  w_taken = (rs_data != rt_data);
      OP_BLEZ: w_taken = rs_data[DATA_WIDTH-1] || (rs_data == '0);
      OP_BGTZ: w_taken = !rs_data[DATA_WIDTH-1] && (rs_data != '0);
      OP_ADDI, OP_ADDIU, OP_LW: begin
        w_alu_op = ALU_ADD; w_use_imm = 1'b1; w_we = 1'b1;
      end
      OP_SW:    begin w_alu_op = ALU_ADD;  w_use_imm = 1'b1; end
      OP_SLTI:  begin w_alu_op = ALU_SLT;  w_use_imm = 1'b1; w_we = 1'b1; end
      OP_SLTIU: begin w_alu_op = ALU_SLTU; w_use_imm = 1'b1; w_we = 1'b1; end
      OP_ANDI:  begin w_alu_op = ALU_AND;  w_use_imm = 1'b1; w_zext = 1'b1; w_we = 1'b1; end
      OP_ORI:   begin w_alu_op = ALU_OR;   w_use_imm = 1'b1; w_zext = 1'b1; w_we = 1'b1; end
      OP_XORI:  begin w_alu_op = ALU_XOR;  w_use_imm = 1'b1; w_zext = 1'b1; w_we = 1'b1; end
      OP_LUI:   begin w_alu_op = ALU_LUI;  w_we = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (w_alu_op)
      ALU_ADD:  w_result = rs_data + w_opb;
      ALU_SUB:  w_result = rs_data - w_opb;
      ALU_AND:  w_result = rs_data & w_opb;
      ALU_OR:   w_result = rs_data | w_opb;
      ALU_XOR:  w_result = rs_data ^ w_opb;
      ALU_NOR:  w_result = ~(rs_data | w_opb);
      ALU_SLT:  w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: w_result = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
      ALU_LUI:  w_result = w_zimm << 16;
      ALU_SLL:  w_result = rt_data << w_shamt;
      ALU_SRL:  w_result = rt_data >> w_shamt;
      ALU_SRA:  w_result = DATA_WIDTH'($signed(rt_data) >>> w_shamt);
      ALU_LINK: w_result = DATA_WIDTH'(w_pc8);
      ALU_HI:   w_result = w_hi;
      ALU_LO:   w_result = w_lo;
      default:  w_result = '0;
    endcase
  end

  mult_div_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .MD_CYCLES (MD_CYCLES)
  ) u_md (
    .i_clk  (clock),
    .i_rst_n(reset_n),
    .i_start(w_accept & w_md_start),
    .i_op   (w_md_op),
    .i_a    (rs_data),
    .i_b    (rt_data),
    .o_busy (w_md_busy),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_result    <= '0;
      dest_reg      <= '0;
      reg_write     <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      valid_out     <= 1'b0;
    end else begin
      valid_out    <= w_accept;
      reg_write    <= w_accept & w_we;
      branch_taken <= w_accept & w_taken;
      if (w_accept) begin
        alu_result    <= w_result;
        dest_reg      <= w_dest;
        branch_target <= w_target;
      end
    end
  end

  // Combinational from the unit's state so reset drops it without a clock.
  assign stall = w_md_busy;

endmodule

// File: tb/tb_execute.sv
module tb_execute;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable_execute;
  logic [31:0] pc;
  logic [5:0]  opcode, func;
  logic [4:0]  rt, rd, sa;
  logic [25:0] imm;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_result, branch_target;
  logic [4:0]  dest_reg;
  logic        reg_write, branch_taken, valid_out, stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  execute #(.DATA_WIDTH(32), .MD_CYCLES(32), .LINK_REG(31)) dut (
    .clock(clock), .reset_n(reset_n), .enable_execute(enable_execute),
    .pc(pc), .opcode(opcode), .func(func), .rt(rt), .rd(rd), .sa(sa),
    .imm(imm), .rs_data(rs_data), .rt_data(rt_data),
    .alu_result(alu_result), .dest_reg(dest_reg), .reg_write(reg_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .valid_out(valid_out), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] s, input logic [25:0] im,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    opcode = op; func = fn; rt = t; rd = d; sa = s; imm = im;
    rs_data = a; rt_data = b; pc = p; enable_execute = 1'b1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] s, input logic [25:0] im,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    drive(op, fn, t, d, s, im, a, b, p);
    @(posedge clock); #1;
    enable_execute = 1'b0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] d, input logic [4:0] s,
                       input logic [31:0] a, input logic [31:0] b);
    issue(OP_RTYPE, fn, 5'd2, d, s, 26'd0, a, b, 32'h0);
  endtask

  task automatic itype(input logic [5:0] op, input logic [4:0] t, input logic [15:0] im,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    issue(op, 6'h00, t, 5'd9, 5'd0, {10'd0, im}, a, b, p);
  endtask

  // Waits for the mult/div unit to finish; returns cycles spent waiting.
  task automatic wait_md(input string tag, output int cycles);
    cycles = 0;
    while (stall && cycles < 200) begin
      @(posedge clock); #1;
      cycles++;
    end
    check({tag, "_done"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    rtype(FN_MFHI, 5'd10, 5'd0, 32'h0, 32'h0);
    check({tag, "_hi"}, alu_result, exp_hi);
    rtype(FN_MFLO, 5'd11, 5'd0, 32'h0, 32'h0);
    check({tag, "_lo"}, alu_result, exp_lo);
  endtask

  int  cyc;
  bit  saw_valid;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'h0, 32'h0);
    enable_execute = 1'b0;
    #22;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_target", branch_target, 32'd0);
    check("rst_flags", {27'd0, dest_reg, reg_write, branch_taken}, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("idle_valid", {31'd0, valid_out}, 32'd0);

    // ADDIU with sign-extended -1, latency and single-cycle valid
    itype(OP_ADDIU, 5'd5, 16'hFFFF, 32'd7, 32'd0, 32'h0);
    check("addiu_result", alu_result, 32'd6);
    check("addiu_dest", {27'd0, dest_reg}, 32'd5);
    check("addiu_flags", {30'd0, valid_out, reg_write}, 32'd3);
    @(posedge clock); #1;
    check("addiu_valid_drop", {30'd0, valid_out, reg_write}, 32'd0);

    rtype(FN_ADDU, 5'd3, 5'd0, 32'hFFFF_FFFF, 32'd2);
    check("addu_wrap", alu_result, 32'd1);
    check("addu_dest", {27'd0, dest_reg}, 32'd3);
    rtype(FN_SUBU, 5'd3, 5'd0, 32'd5, 32'd7);
    check("subu", alu_result, 32'hFFFF_FFFE);
    rtype(FN_SLT, 5'd3, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("slt_signed", alu_result, 32'd1);
    rtype(FN_SLTU, 5'd3, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("sltu", alu_result, 32'd0);
    rtype(FN_NOR, 5'd3, 5'd0, 32'h0F0F_0000, 32'h0000_00F0);
    check("nor", alu_result, 32'hF0F0_FF0F);
    rtype(FN_SRA, 5'd3, 5'd4, 32'h0, 32'h8000_0000);
    check("sra", alu_result, 32'hF800_0000);
    rtype(FN_SRLV, 5'd3, 5'd0, 32'h0000_0024, 32'h8000_0000);
    check("srlv", alu_result, 32'h0800_0000);
    rtype(FN_SLL, 5'd3, 5'd8, 32'h0, 32'h0000_00AB);
    check("sll", alu_result, 32'h0000_AB00);
    itype(OP_SLTIU, 5'd6, 16'hFFFF, 32'd5, 32'd0, 32'h0);
    check("sltiu_sext", alu_result, 32'd1);
    itype(OP_SLTI, 5'd6, 16'hFFFF, 32'd5, 32'd0, 32'h0);
    check("slti", alu_result, 32'd0);
    itype(OP_ORI, 5'd6, 16'h8001, 32'hF000_0000, 32'd0, 32'h0);
    check("ori_zext", alu_result, 32'hF000_8001);
    itype(OP_LUI, 5'd7, 16'h1234, 32'h0, 32'd0, 32'h0);
    check("lui", alu_result, 32'h1234_0000);
    check("lui_dest", {27'd0, dest_reg}, 32'd7);
    itype(OP_LW, 5'd8, 16'hFFFC, 32'h0000_0100, 32'd0, 32'h0);
    check("lw_addr", alu_result, 32'h0000_00FC);
    check("lw_we", {31'd0, reg_write}, 32'd1);
    itype(OP_SW, 5'd8, 16'h0004, 32'h0000_0100, 32'd0, 32'h0);
    check("sw_addr", alu_result, 32'h0000_0104);
    check("sw_we", {30'd0, valid_out, reg_write}, 32'd2);

    // Branches and jumps
    itype(OP_BEQ, 5'd1, 16'h0003, 32'h55, 32'h55, 32'h8002_0000);
    check("beq_taken", {30'd0, branch_taken, reg_write}, 32'd2);
    check("beq_target", branch_target, 32'h8002_0010);
    itype(OP_BNE, 5'd1, 16'h0003, 32'h55, 32'h55, 32'h8002_0000);
    check("bne_not_taken", {31'd0, branch_taken}, 32'd0);
    itype(OP_BEQ, 5'd1, 16'hFFFE, 32'h1, 32'h1, 32'h8002_0000);
    check("beq_back_target", branch_target, 32'h8001_FFFC);
    itype(OP_BLEZ, 5'd1, 16'h0001, 32'h0, 32'h0, 32'h0);
    check("blez_zero", {31'd0, branch_taken}, 32'd1);
    itype(OP_BGTZ, 5'd1, 16'h0001, 32'h0, 32'h0, 32'h0);
    check("bgtz_zero", {31'd0, branch_taken}, 32'd0);
    issue(OP_JAL, 6'h00, 5'd0, 5'd0, 5'd0, 26'h0008000, 32'h0, 32'h0, 32'h8002_0100);
    check("jal_target", branch_target, 32'h8002_0000);
    check("jal_link", alu_result, 32'h8002_0108);
    check("jal_dest", {27'd0, dest_reg}, 32'd31);
    check("jal_flags", {29'd0, valid_out, reg_write, branch_taken}, 32'd7);
    rtype(FN_JR, 5'd0, 5'd0, 32'h1234_5678, 32'h0);
    check("jr_target", branch_target, 32'h1234_5678);
    check("jr_flags", {30'd0, reg_write, branch_taken}, 32'd1);
    issue(6'h3F, 6'h00, 5'd1, 5'd2, 5'd0, 26'd0, 32'h1, 32'h2, 32'h0);
    check("unknown_nop", {29'd0, valid_out, reg_write, branch_taken}, 32'd4);

    // MULT -3*5 with an MFLO held behind the stall
    rtype(FN_MULT, 5'd0, 5'd0, 32'hFFFF_FFFD, 32'd5);
    check("mult_retire", {29'd0, valid_out, reg_write, stall}, 32'd5);
    drive(OP_RTYPE, FN_MFLO, 5'd0, 5'd12, 5'd0, 26'd0, 32'h0, 32'h0, 32'h0);
    cyc = 0; saw_valid = 1'b0;
    while (stall && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      if (valid_out) saw_valid = 1'b1;
    end
    check("mult_stall_cycles", cyc, 32'd32);
    check("held_no_valid", {31'd0, saw_valid}, 32'd0);
    @(posedge clock); #1;
    enable_execute = 1'b0;
    check("held_mflo", alu_result, 32'hFFFF_FFF1);
    check("held_mflo_flags", {30'd0, valid_out, reg_write}, 32'd3);
    check("held_mflo_dest", {27'd0, dest_reg}, 32'd12);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    rtype(FN_MULTU, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd2);
    wait_md("multu", cyc);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

`ifdef EXEC_DIV_EN
    rtype(FN_DIV, 5'd0, 5'd0, 32'd17, 32'd5);
    check("div_stall", {31'd0, stall}, 32'd1);
    wait_md("div_pos", cyc);
    read_hilo("div_pos", 32'd2, 32'd3);
    rtype(FN_DIV, 5'd0, 5'd0, 32'hFFFF_FFEF, 32'd5);
    wait_md("div_neg", cyc);
    read_hilo("div_neg", 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    rtype(FN_DIV, 5'd0, 5'd0, 32'd9, 32'd0);
    wait_md("div_zero", cyc);
    read_hilo("div_zero", 32'd9, 32'hFFFF_FFFF);
    rtype(FN_DIVU, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd16);
    wait_md("divu", cyc);
    read_hilo("divu", 32'd15, 32'h0FFF_FFFF);
`else
    rtype(FN_DIV, 5'd0, 5'd0, 32'd17, 32'd5);
    check("div_off_retire", {30'd0, valid_out, stall}, 32'd2);
    @(posedge clock); #1;
    check("div_off_stall", {31'd0, stall}, 32'd0);
    rtype(FN_DIVU, 5'd0, 5'd0, 32'd9, 32'd0);
    check("divu_off_stall", {31'd0, stall}, 32'd0);
    read_hilo("div_off", 32'h0000_0001, 32'hFFFF_FFFE);
`endif

    // Reset mid-MULTU aborts the operation
    rtype(FN_MULTU, 5'd0, 5'd0, 32'd3, 32'd4);
    repeat (10) @(posedge clock);
    #2;
    check("pre_reset_stall", {31'd0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_stall", {31'd0, stall}, 32'd0);
    check("async_valid", {31'd0, valid_out}, 32'd0);
    check("async_result", alu_result, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_stall", {31'd0, stall}, 32'd0);
    read_hilo("post_reset", 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
